// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, frame marker,
// and instruction field positions also used by the decode stage.
package program_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int INSN_COND_MSB = 31;
  localparam int INSN_COND_LSB = 28;
  localparam int INSN_OP_MSB   = 27;
  localparam int INSN_OP_LSB   = 24;
  localparam int INSN_S_BIT    = 23;
  localparam int INSN_RD_MSB   = 22;
  localparam int INSN_RD_LSB   = 19;
  localparam int INSN_RS1_MSB  = 18;
  localparam int INSN_RS1_LSB  = 15;
  localparam int INSN_RS2_MSB  = 14;
  localparam int INSN_RS2_LSB  = 11;

  // Big-endian packing: earlier bytes migrate toward the MSB.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  data);
    return {word[23:0], data};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake into the loader; a transfer happens when rx_valid & rx_ready.
interface program_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader_word_packer.sv
// Packs payload bytes MSB-first into 32-bit words while folding them into an XOR checksum.
module program_loader_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [7:0]  csum_o,
    output logic        word_full_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        if (clear_i) begin
            idx_d  = 2'd0;
            csum_d = 8'd0;
        end else if (byte_vld_i) begin
            shift_d = shift_in_byte(shift_q, byte_i);
            csum_d  = csum_q ^ byte_i;
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= 32'd0;
            idx_q   <= 2'd0;
            csum_q  <= 8'd0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

    assign word_o      = shift_q;
    assign csum_o      = csum_q;
    assign word_full_o = byte_vld_i & ~clear_i & (idx_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Frame receiver that writes a program into instruction RAM and holds the CPU
// in reset until the whole frame has arrived with a matching checksum.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_W        = 8,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int         BASE_ADDR     = 0,
    parameter bit         HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              pc_reset,
    program_loader_if.slave   rx,
    output logic              mem_wr_en,
    output logic [15:0]       mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CW = ADDR_W + 1;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     words_q, words_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              pk_clear;
    logic              pk_vld;
    logic [31:0]       pk_word;
    logic [7:0]        pk_csum;
    logic              pk_full;
    logic [ADDR_W-1:0] wr_addr;
    logic [CW-1:0]     words_inc;

    assign rx.rx_ready = (state_q != ST_WRITE);
    assign accept      = rx.rx_valid & rx.rx_ready;
    assign pk_vld      = accept & (state_q == ST_DATA);
    assign words_inc   = words_q + 1'b1;

    program_loader_word_packer u_packer (
        .clk         (clk),
        .rst         (pc_reset),
        .clear_i     (pk_clear),
        .byte_vld_i  (pk_vld),
        .byte_i      (rx.rx_data),
        .word_o      (pk_word),
        .csum_o      (pk_csum),
        .word_full_o (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        words_d  = words_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        pk_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // Only a sync marker opens a frame; any other byte is dropped.
                if (accept && (rx.rx_data == SYNC_BYTE)) begin
                    state_d  = ST_COUNT;
                    hold_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    words_d  = '0;
                    pk_clear = 1'b1;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    // A zero count encodes a full memory image.
                    n_d     = (rx.rx_data == 8'd0) ? CW'(1 << ADDR_W) : CW'(rx.rx_data);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (pk_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                words_d = words_inc;
                state_d = (words_inc == n_q) ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (accept) begin
                    if (rx.rx_data == pk_csum) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pc_reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            words_q <= '0;
            hold_q  <= HOLD_AT_RESET;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Address wraps naturally at the RAM depth.
    assign wr_addr      = ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
    assign mem_addr     = 16'(wr_addr);
    assign mem_wr_en    = (state_q == ST_WRITE);
    assign mem_wr_data  = pk_word;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed byte streams with hand-computed writes and flags.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        pc_reset;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [8:0]  words_loaded;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int ready_bad = 0;

    program_loader_if rxif ();

    program_loader dut (
        .clk          (clk),
        .pc_reset     (pc_reset),
        .rx           (rxif),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write strobes and the rule that rx_ready drops only while writing.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) wr_cnt++;
        if (rxif.rx_ready === mem_wr_en) ready_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        rxif.rx_data  = b;
        rxif.rx_valid = 1'b1;
        while (rxif.rx_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        chk("send_ready_timeout", 32'(guard < 16), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rxif.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic check_write(input string tag, input logic [15:0] addr, input logic [31:0] data);
        chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, "_data"}, mem_wr_data, data);
        chk({tag, "_ready_low"}, 32'(rxif.rx_ready), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rx_ready"}, 32'(rxif.rx_ready), 32'd1);
        chk({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"}, mem_wr_data, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(load_error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic good_frame1(input string tag);
        int c0;
        c0 = wr_cnt;
        send(8'hA5);
        chk({tag, "_hold_on_sync"}, 32'(cpu_hold), 32'd1);
        send(8'h01);
        send_word(32'hE123_4567);
        check_write(tag, 16'h0000, 32'hE123_4567);
        send(8'hE0);
        chk({tag, "_done"}, 32'(load_done), 32'd1);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_err"}, 32'(load_error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd1);
        chk({tag, "_wr_count"}, 32'(wr_cnt - c0), 32'd1);
    endtask

    initial begin
        int c0;
        int c1;
        logic [7:0]  ib;
        logic [7:0]  csum;
        logic [31:0] w;

        pc_reset      = 1'b1;
        rxif.rx_valid = 1'b0;
        rxif.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset("reset");
        pc_reset = 1'b0;
        @(negedge clk);

        // Single-word frame
        good_frame1("t1");

        // Three-word frame, checksum 0xCC
        c0 = wr_cnt;
        send(8'hA5);
        send(8'h03);
        send_word(32'h1122_3344);
        check_write("t2_w0", 16'h0000, 32'h1122_3344);
        send_word(32'h5566_7788);
        check_write("t2_w1", 16'h0001, 32'h5566_7788);
        send_word(32'h99AA_BBCC);
        check_write("t2_w2", 16'h0002, 32'h99AA_BBCC);
        send(8'hCC);
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_words", 32'(words_loaded), 32'd3);
        chk("t2_wr_count", 32'(wr_cnt - c0), 32'd3);
        chk("t2_ready_only_in_write", 32'(ready_bad), 32'd0);

        // Bad checksum, then recovery
        send(8'hA5);
        send(8'h01);
        send_word(32'hE123_4567);
        check_write("t3", 16'h0000, 32'hE123_4567);
        send(8'h00);
        chk("t3_err", 32'(load_error), 32'd1);
        chk("t3_done", 32'(load_done), 32'd0);
        chk("t3_hold", 32'(cpu_hold), 32'd1);
        good_frame1("t3_recover");

        // Non-sync bytes while idle are discarded
        c0 = wr_cnt;
        send(8'h00);
        send(8'hFF);
        send(8'hA4);
        chk("t4_no_writes", 32'(wr_cnt - c0), 32'd0);
        chk("t4_done_kept", 32'(load_done), 32'd1);
        chk("t4_hold_kept", 32'(cpu_hold), 32'd0);
        send(8'hA5);
        chk("t4_sync_hold", 32'(cpu_hold), 32'd1);
        chk("t4_sync_done_clr", 32'(load_done), 32'd0);

        // Reset mid-frame, with a sync byte offered during the reset cycle
        c0 = wr_cnt;
        send(8'h02);
        send_word(32'h0102_0304);
        check_write("t5_w0", 16'h0000, 32'h0102_0304);
        send(8'h05);
        send(8'h06);
        pc_reset      = 1'b1;
        rxif.rx_valid = 1'b1;
        rxif.rx_data  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        pc_reset      = 1'b0;
        rxif.rx_valid = 1'b0;
        check_reset("t5_abort");
        chk("t5_wr_once", 32'(wr_cnt - c0), 32'd1);
        repeat (2) @(negedge clk);
        good_frame1("t5_after");

        // Full 256-word image with a payload 0xA5 in every word and stalls
        c0 = wr_cnt;
        csum = 8'h00;
        send(8'hA5);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            w = {8'hA5, ib, 8'h00, ~ib};
            csum = csum ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send_word(w);
            check_write("t6", 16'(ib), w);
            if ((i % 64) == 63 && i != 255) begin
                @(negedge clk);
                c1 = wr_cnt;
                rxif.rx_data = 8'hA5;
                repeat (3) @(negedge clk);
                chk("t6_gap_no_write", 32'(wr_cnt - c1), 32'd0);
            end
        end
        send(csum);
        chk("t6_done", 32'(load_done), 32'd1);
        chk("t6_hold", 32'(cpu_hold), 32'd0);
        chk("t6_words", 32'(words_loaded), 32'd256);
        chk("t6_wr_count", 32'(wr_cnt - c0), 32'd256);
        chk("final_ready_only_in_write", 32'(ready_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
